// File: rtl/product_accumulator.sv
// Packet accumulator downstream of the multiplier: sums extended products per packet
// and holds one registered result. Optional clamping via PRODUCT_ACCUMULATOR_SATURATE_EN.
//
// state   | meaning
// ST_ACC  | accepting products, building the packet sum
// ST_HOLD | result presented downstream, upstream stalled
module product_accumulator #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 2*N+8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             up_vld_i,
  output logic             up_rdy_o,
  input  logic [2*N-1:0]   up_res_i,
  input  logic             up_signed_i,
  input  logic             up_last_i,
  output logic             down_vld_o,
  input  logic             down_rdy_i,
  output logic [ACC_W-1:0] down_sum_o,
  output logic [7:0]       down_cnt_o,
  output logic             down_ovf_o
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [7:0]         ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;

  logic               beat;
  logic               mode_eff;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W:0]     sum_wide;
  logic               ovf_now;
  logic [ACC_W-1:0]   acc_next;
  logic [7:0]         cnt_next;
  logic               ovf_next;

  assign up_rdy_o   = (state_q == ST_ACC);
  assign down_vld_o = (state_q == ST_HOLD);
  assign down_sum_o = sum_q;
  assign down_cnt_o = ocnt_q;
  assign down_ovf_o = oovf_q;

  assign beat = up_vld_i && up_rdy_o;

  // Mode comes from the live input only on the first beat of a packet.
  always_comb begin
    mode_eff = (cnt_q == 8'd0) ? up_signed_i : mode_q;
    ext      = mode_eff ? ACC_W'($signed(up_res_i)) : ACC_W'(up_res_i);
    sum_wide = {1'b0, acc_q} + {1'b0, ext};
    if (mode_eff) begin
      ovf_now = (acc_q[ACC_W-1] == ext[ACC_W-1]) &&
                (sum_wide[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = sum_wide[ACC_W];
    end
    ovf_next = ovf_q | ovf_now;
    cnt_next = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, the sticky flag freezes the accumulator for the rest of the packet.
    if (ovf_q) begin
      acc_next = acc_q;
    end else if (ovf_now) begin
      if (mode_eff) begin
        acc_next = acc_q[ACC_W-1] ? SMIN : SMAX;
      end else begin
        acc_next = UMAX;
      end
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
`else
    acc_next = sum_wide[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          if (up_last_i) begin
            sum_d   = acc_next;
            ocnt_d  = cnt_next;
            oovf_d  = ovf_next;
            acc_d   = '0;
            cnt_d   = 8'd0;
            ovf_d   = 1'b0;
            mode_d  = 1'b0;
            state_d = ST_HOLD;
          end else begin
            acc_d  = acc_next;
            cnt_d  = cnt_next;
            ovf_d  = ovf_next;
            mode_d = mode_eff;
          end
        end
      end
      ST_HOLD: begin
        if (down_rdy_i) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= 8'd0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 24-bit and a 17-bit instance share stimulus.
// Expected overflow results follow PRODUCT_ACCUMULATOR_SATURATE_EN.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_vld = 1'b0;
  logic [15:0] up_res = '0;
  logic        up_signed = 1'b0;
  logic        up_last = 1'b0;
  logic        down_rdy = 1'b0;

  logic        rdy_a, vld_a, ovf_a;
  logic [23:0] sum_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [16:0] sum_b;
  logic [7:0]  cnt_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N(8), .ACC_W(24)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .up_vld_i(up_vld), .up_rdy_o(rdy_a),
    .up_res_i(up_res), .up_signed_i(up_signed), .up_last_i(up_last),
    .down_vld_o(vld_a), .down_rdy_i(down_rdy), .down_sum_o(sum_a),
    .down_cnt_o(cnt_a), .down_ovf_o(ovf_a)
  );

  product_accumulator #(.N(8), .ACC_W(17)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .up_vld_i(up_vld), .up_rdy_o(rdy_b),
    .up_res_i(up_res), .up_signed_i(up_signed), .up_last_i(up_last),
    .down_vld_o(vld_b), .down_rdy_i(down_rdy), .down_sum_o(sum_b),
    .down_cnt_o(cnt_b), .down_ovf_o(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] res, input logic sgn, input logic last);
    int guard = 0;
    while (!rdy_a && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_a) check("rdy_timeout", 32'(rdy_a), 32'd1);
    up_vld    = 1'b1;
    up_res    = res;
    up_signed = sgn;
    up_last   = last;
    @(negedge clk);
    up_vld  = 1'b0;
    up_last = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [23:0] s, input logic [7:0] c,
                         input logic o);
    check({tag, "_vld"}, 32'(vld_a), 32'd1);
    check({tag, "_rdy"}, 32'(rdy_a), 32'd0);
    check({tag, "_sum"}, 32'(sum_a), 32'(s));
    check({tag, "_cnt"}, 32'(cnt_a), 32'(c));
    check({tag, "_ovf"}, 32'(ovf_a), 32'(o));
  endtask

  task automatic check_b(input string tag, input logic [16:0] s, input logic [7:0] c,
                         input logic o);
    check({tag, "_bvld"}, 32'(vld_b), 32'd1);
    check({tag, "_bsum"}, 32'(sum_b), 32'(s));
    check({tag, "_bcnt"}, 32'(cnt_b), 32'(c));
    check({tag, "_bovf"}, 32'(ovf_b), 32'(o));
  endtask

  task automatic consume();
    down_rdy = 1'b1;
    @(negedge clk);
    down_rdy = 1'b0;
    check("consume_rdy", 32'(rdy_a), 32'd1);
    check("consume_vld", 32'(vld_a), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] exp_u3, exp_u4, exp_sp, exp_sn;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    exp_u3 = 17'h1FFFF;
    exp_u4 = 17'h1FFFF;
    exp_sp = 17'h0FFFF;
    exp_sn = 17'h10000;
`else
    exp_u3 = 17'h0FA03;
    exp_u4 = 17'h1F804;
    exp_sp = 17'h17FFD;
    exp_sn = 17'h08000;
`endif

    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy_a), 32'd1);
    check("rst_vld", 32'(vld_a), 32'd0);
    check("rst_sum", 32'(sum_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-packet discards the partial sum
    send_beat(16'h1234, 1'b0, 1'b0);
    send_beat(16'h1234, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", 32'(vld_a), 32'd0);
    check("midrst_rdy", 32'(rdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(16'h0005, 1'b0, 1'b1);
    check_a("single", 24'h000005, 8'd1, 1'b0);
    consume();

    send_beat(16'hFFFA, 1'b1, 1'b0);
    send_beat(16'h000A, 1'b1, 1'b1);
    check_a("signed", 24'h000004, 8'd2, 1'b0);
    consume();

    send_beat(16'hFFFA, 1'b0, 1'b0);
    send_beat(16'h000A, 1'b0, 1'b1);
    check_a("unsigned", 24'h010004, 8'd2, 1'b0);
    consume();

    // later up_signed ignored: packet stays signed
    send_beat(16'h000A, 1'b1, 1'b0);
    send_beat(16'hFFFA, 1'b0, 1'b1);
    check_a("modelatch", 24'h000004, 8'd2, 1'b0);
    consume();

    for (int i = 0; i < 3; i++) send_beat(16'hFE01, 1'b0, i == 2);
    check_a("uovf3", 24'h02FA03, 8'd3, 1'b0);
    check_b("uovf3", exp_u3, 8'd3, 1'b1);
    consume();

    for (int i = 0; i < 4; i++) send_beat(16'hFE01, 1'b0, i == 3);
    check_a("uovf4", 24'h03F804, 8'd4, 1'b0);
    check_b("uovf4", exp_u4, 8'd4, 1'b1);
    consume();

    for (int i = 0; i < 3; i++) send_beat(16'h7FFF, 1'b1, i == 2);
    check_a("sovfp", 24'h017FFD, 8'd3, 1'b0);
    check_b("sovfp", exp_sp, 8'd3, 1'b1);
    consume();

    for (int i = 0; i < 3; i++) send_beat(16'h8000, 1'b1, i == 2);
    check_a("sovfn", 24'hFE8000, 8'd3, 1'b0);
    check_b("sovfn", exp_sn, 8'd3, 1'b1);
    consume();

    // backpressure: result held, upstream offers ignored
    send_beat(16'h0003, 1'b0, 1'b1);
    check_a("bp0", 24'h000003, 8'd1, 1'b0);
    up_vld    = 1'b1;
    up_res    = 16'h00FF;
    up_signed = 1'b0;
    up_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_a("bp", 24'h000003, 8'd1, 1'b0);
    end
    up_vld  = 1'b0;
    up_last = 1'b0;
    consume();
    send_beat(16'h0007, 1'b0, 1'b1);
    check_a("after_bp", 24'h000007, 8'd1, 1'b0);
    consume();

    for (int i = 0; i < 300; i++) send_beat(16'h0000, 1'b0, i == 299);
    check_a("cntsat", 24'h000000, 8'd255, 1'b0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator stage that sits directly downstream of the signed/unsigned multiplier. It consumes a stream of 2n-bit products over a valid/ready handshake and sums each packet, delimited by a `last` flag, into a wider accumulator. Each product is sign-extended or zero-extended according to the packet's signedness. It presents one registered sum per packet to the next stage, with a term count and an overflow flag.

## Interface
- `n`, default 8: multiplier operand width; products are 2n bits.
- `acc_w`, default 2n+8: accumulator and output width; legal range acc_w ≥ 2n.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `up_vld`  in  1: upstream product valid.
- `up_rdy`  out  1: stage can accept a product.
- `up_res`  in  2n: product from the multiplier.
- `up_signed`  in  1: product is two's-complement when 1, unsigned when 0.
- `up_last`  in  1: final product of the current packet.
- `down_vld`  out  1: packet result valid.
- `down_rdy`  in  1: downstream accepts the result.
- `down_sum`  out  acc_w: packet sum.
- `down_cnt`  out  8: number of products in the packet, saturating at 255.
- `down_ovf`  out  1: accumulation overflowed during the packet.

## Operation
- Two states:
  - ACC (reset state): `up_rdy`=1, `down_vld`=0.
  - HOLD: `up_rdy`=0, `down_vld`=1.
- Beat acceptance: a beat is accepted when `up_vld && up_rdy`.
- First beat of a packet (internal count = 0): latches the packet mode from `up_signed`. `up_signed` on later beats of the same packet is ignored.
- Extension: each accepted product is extended to acc_w bits by sign-extension in signed mode and zero-extension in unsigned mode, then added to the accumulator.
- Overflow detection:
  - Signed mode: both addends have the same sign and the result sign differs.
  - Unsigned mode: carry out of bit acc_w-1.
  - The overflow flag is sticky for the packet.
- Beat with `up_last`=1:
  - The final sum, count and overflow flag are loaded into the output registers.
  - Internal accumulator, count, overflow and mode are cleared.
  - State moves to HOLD.
- HOLD exit: when `down_rdy`=1, the result is consumed and the state returns to ACC. Outputs keep their values until the next packet result is loaded.
- A single-beat packet (`up_last` on the first beat) is legal and yields sum = extended product, cnt = 1.
- Count: increments on every accepted beat and holds at 255 (no wrap).

## Timing
- Reset values: `up_rdy`=1, `down_vld`=0, `down_sum`=0, `down_cnt`=0, `down_ovf`=0. Accumulator, count, overflow and mode all clear.
- Reset asserted mid-packet or in HOLD: the partial packet and any pending result are discarded immediately. No output is produced for that packet.
- Latency: last beat accepted on edge t → `down_vld`=1 with valid data after edge t (visible in cycle t+1).
- Handshake timing:
  - `down_vld` stays high with stable data until a cycle with `down_rdy`=1.
  - The state returns to ACC on that edge.
  - `up_rdy` rises the cycle after the result is consumed.
  - Minimum packet period is therefore 2 cycles.
- `up_rdy` is a pure function of state and does not depend on `up_vld` or `down_rdy`.
- Upstream data is ignored whenever `up_rdy`=0.

## Configuration
- Macro: `PRODUCT_ACCUMULATOR_SATURATE_EN`.
- Defined:
  - On overflow, the accumulator clamps to the limit of the packet's mode and stays clamped for the rest of the packet.
  - Signed limits: max 2^(acc_w-1)-1, min -2^(acc_w-1).
  - Unsigned limit: max 2^acc_w-1.
  - Later beats add nothing after clamping.
  - `down_ovf` is still set.
- Undefined: the accumulator wraps modulo 2^acc_w and `down_ovf` is set.

## Test plan
- Reset: assert `rst_n`=0 mid-packet after 2 beats, then release → `down_vld`=0. A following 1-beat packet of 0x0005 unsigned gives sum 5, cnt 1, no stale partial sum.
- Signed: n=8, acc_w=24, beats 0xFFFA then 0x000A (last), `up_signed`=1 → `down_sum`=0x000004, cnt 2, ovf 0, `down_vld` high the cycle after the last beat.
- Unsigned: same beats with `up_signed`=0 → `down_sum`=0x010004, cnt 2, ovf 0.
- Overflow: acc_w=17, unsigned, three beats of 0xFE01:
  - Macro undefined → sum 0x0FA03, ovf 1.
  - Macro defined → sum 0x1FFFF, ovf 1.
- Backpressure: hold `down_rdy`=0 for 5 cycles after the result appears → `down_vld`, sum and cnt stable, `up_rdy`=0, and upstream beats are not consumed. Then `down_rdy`=1 for one cycle → `up_rdy`=1 the next cycle.
- Count saturation: 300 beats of 0x0000 with the last flag on beat 300 → cnt 255, sum 0.
